reorder_buffer: RTL and testbench
=================================

Name: reorder_buffer

Overview:
- Circular in-order retirement buffer between decoder/issue and the register file.
- Allocates one entry per issued instruction and collects results from the ALU and LSB result buses.
- Answers operand-forwarding queries from the decoder.
- Commits one entry per cycle to the register file; on the commit of a mispredicted branch or a JALR, it raises rollback and a redirect PC.

Parameters:
- ROB_SZ, 16, number of entries (power of two).
- ROB_ID_W, 4, log2(ROB_SZ); matches `ROB_ID_WID`.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global enable; when low, all state and outputs hold
- issue_valid  in  1  allocate an entry this cycle
- issue_type  in  2  0=NORM, 1=BR, 2=STORE, 3=JALR
- issue_rd  in  5  destination register (0 = none)
- issue_pc  in  32  instruction PC
- issue_pred_taken  in  1  predictor decision (BR only)
- issue_ready  in  1  value known at issue (LUI/AUIPC/JAL)
- issue_value  in  32  value when issue_ready
- rob_full  out  1  combinational, count==ROB_SZ
- alloc_rob_id  out  ROB_ID_W  combinational tail index; the id the next issue receives
- alu_valid  in  1  ALU result broadcast
- alu_rob_id  in  ROB_ID_W  ALU result tag
- alu_value  in  32  ALU result value
- alu_jump  in  1  ALU actual taken
- alu_jump_pc  in  32  ALU correct next PC
- lsb_valid  in  1  LSB broadcast (load data, or store address-ready)
- lsb_rob_id  in  ROB_ID_W  LSB tag
- lsb_value  in  32  LSB result value
- q1_rob_id  in  ROB_ID_W  decoder query 1 tag
- q1_ready  out  1  query 1 result ready
- q1_value  out  32  query 1 result value
- q2_rob_id  in  ROB_ID_W  decoder query 2 tag
- q2_ready  out  1  query 2 result ready
- q2_value  out  32  query 2 result value
- is_commit  out  1  registered; regfile commit strobe
- commit_rd  out  5  registered; committed destination register
- commit_data  out  32  registered; committed value
- commit_rob_id  out  ROB_ID_W  registered; committed entry id
- commit_pc  out  32  registered; committed PC
- commit_store  out  1  registered pulse; LSB may write memory for commit_rob_id
- rollback  out  1  registered one-cycle pulse
- redirect_pc  out  32  registered; valid with rollback

Behaviour:
- Reset values:
  - head=tail=count=0; all entries invalid.
  - is_commit, commit_store and rollback = 0.
  - commit_rd, commit_data, commit_rob_id, commit_pc and redirect_pc = 0.
- Per-entry state: busy, ready, type, rd, pc, value, pred_taken, jump, jump_pc.
- Issue:
  - When issue_valid && !rob_full, entry[tail] is written with busy=1 and ready=issue_ready.
  - tail increments modulo ROB_SZ.
  - issue_valid while full is ignored; no state change.
- Writeback:
  - On alu_valid, entry[alu_rob_id] gets ready=1, value, jump and jump_pc.
  - On lsb_valid, entry[lsb_rob_id] gets ready=1 and value.
  - Both buses may fire in the same cycle to different ids.
  - A writeback to a non-busy entry is ignored.
- Query:
  - Combinational. qN_ready=1 and qN_value=entry value when the entry is ready.
  - Otherwise qN_ready=1 with the bus value when alu_valid or lsb_valid carries a matching tag this cycle (ALU has priority).
  - Otherwise qN_ready=0 and qN_value=0.
- Commit:
  - Condition: count>0 and entry[head].ready, using registered state only. Writeback-to-commit latency is therefore at least 1 cycle.
  - Outputs are registered and appear the cycle after the condition.
  - The entry is freed, head increments modulo ROB_SZ and count decrements.
  - Strobes default to 0 every cycle.
  - NORM: is_commit=1 with rd, value, id and pc.
  - STORE: commit_store=1, is_commit=0.
  - BR: is_commit=1 (rd=0). If jump!=pred_taken, rollback=1 and redirect_pc=jump_pc.
  - JALR: is_commit=1 with rd=value, plus rollback=1 and redirect_pc=jump_pc unconditionally.
- Rollback:
  - The cycle rollback is set, all entries are cleared to busy=0 and head=tail=count=0.
  - Any same-cycle issue or writeback is discarded.
  - The next cycle accepts issue normally.
- Simultaneous issue and commit: count stays unchanged. When full, issue is still refused that cycle because rob_full is based on the registered count.
- rst has priority over rdy. With rdy=0, nothing changes and strobes hold at their current value.

Decomposition:
- Entry-type encodings (NORM/BR/STORE/JALR), ROB_SZ and ROB_ID_WID go in the shared const.v.
- One small sub-module is natural: rob_query_port, the combinational tag lookup plus bus forward, instantiated twice.

Test Plan:
- Reset, then issue NORM rd=5 pc=0x100, then alu_valid id=0 value=0xAB. Required: is_commit=1 with rd=5, data=0xAB, rob_id=0 exactly 2 cycles after writeback, then count=0.
- Issue 16 entries. Required: rob_full=1; a 17th issue_valid is ignored (tail stays 0). Then commit one; rob_full drops next cycle; tail wraps to 0.
- Issue ids 0,1,2; write back 2 then 1 then 0. Required: commits in order 0,1,2 on consecutive cycles.
- BR pred_taken=0 at id 0, NORM at id 1. ALU reports id 0 jump=1, jump_pc=0x200. Required: rollback pulse with redirect_pc=0x200 for 1 cycle; id 1 is never committed; alloc_rob_id=0 afterwards.
- q1_rob_id=3 with alu_valid id=3 value=7 in the same cycle. Required: q1_ready=1, q1_value=7. The same query earlier with no bus match gives q1_ready=0.
- STORE at id 0, lsb_valid id 0. Required: commit_store=1 with commit_rob_id=0 and is_commit=0. Also: asserting rst mid-stream clears all outputs next cycle.

Source files
------------

// File: rtl/reorder_buffer_pkg.sv
// reorder_buffer_pkg
//   Shared constants and types for the reorder buffer slice.
//   - ROB_SZ / ROB_ID_WID : default depth and tag width.
//   - rob_type_e          : entry kind recorded at issue.
//   - rob_needs_redirect  : decides whether a committing entry redirects fetch.
package reorder_buffer_pkg;

    localparam int ROB_SZ     = 16;
    localparam int ROB_ID_WID = 4;

    typedef enum logic [1:0] {
        ENT_NORM  = 2'd0,
        ENT_BR    = 2'd1,
        ENT_STORE = 2'd2,
        ENT_JALR  = 2'd3
    } rob_type_e;

    // A JALR always redirects (its target is only known at execute); a branch
    // redirects only when the resolved direction disagrees with the prediction.
    function automatic logic rob_needs_redirect(input rob_type_e typ,
                                                input logic      jump,
                                                input logic      pred_taken);
        return (typ == ENT_JALR) || ((typ == ENT_BR) && (jump != pred_taken));
    endfunction

endpackage

// File: rtl/reorder_buffer_query.sv
// rob_query_port
//   Combinational operand lookup for the decoder.
//   - q_rob_id_i           : tag being asked about
//   - ent_ready_i          : per-entry "holds a valid result" (busy & ready)
//   - ent_value_i          : per-entry stored result
//   - alu_* / lsb_*        : result buses of the current cycle (forwarded)
//   - q_ready_o, q_value_o : answer; value is 0 when not ready
module rob_query_port #(
    parameter int ROB_SZ   = 16,
    parameter int ROB_ID_W = 4
) (
    input  logic [ROB_ID_W-1:0] q_rob_id_i,
    input  logic [ROB_SZ-1:0]   ent_ready_i,
    input  logic [31:0]         ent_value_i [ROB_SZ],
    input  logic                alu_valid_i,
    input  logic [ROB_ID_W-1:0] alu_rob_id_i,
    input  logic [31:0]         alu_value_i,
    input  logic                lsb_valid_i,
    input  logic [ROB_ID_W-1:0] lsb_rob_id_i,
    input  logic [31:0]         lsb_value_i,
    output logic                q_ready_o,
    output logic [31:0]         q_value_o
);

    // Stored result first, then the buses so the decoder does not have to wait
    // a cycle for a value that is being broadcast right now. ALU beats LSB.
    always_comb begin
        q_ready_o = 1'b0;
        q_value_o = 32'd0;
        if (ent_ready_i[q_rob_id_i]) begin
            q_ready_o = 1'b1;
            q_value_o = ent_value_i[q_rob_id_i];
        end else if (alu_valid_i && (alu_rob_id_i == q_rob_id_i)) begin
            q_ready_o = 1'b1;
            q_value_o = alu_value_i;
        end else if (lsb_valid_i && (lsb_rob_id_i == q_rob_id_i)) begin
            q_ready_o = 1'b1;
            q_value_o = lsb_value_i;
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// reorder_buffer
//   Circular in-order retirement buffer. Entries are allocated at issue,
//   completed by the ALU / LSB result buses, and retired one per cycle from
//   the head. Retiring a mispredicted branch or a JALR flushes the buffer and
//   pulses rollback with the redirect PC.
//   Ports:
//   - clk, rst (sync, active high), rdy (global enable / hold)
//   - issue_*        : allocation request; rob_full / alloc_rob_id answer it
//   - alu_*, lsb_*   : result buses
//   - q1_*, q2_*     : operand forwarding queries (combinational)
//   - is_commit, commit_*, commit_store : registered retirement outputs
//   - rollback, redirect_pc             : registered flush pulse + target
module reorder_buffer #(
    parameter int ROB_SZ   = reorder_buffer_pkg::ROB_SZ,
    parameter int ROB_ID_W = reorder_buffer_pkg::ROB_ID_WID
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                issue_valid,
    input  logic [1:0]          issue_type,
    input  logic [4:0]          issue_rd,
    input  logic [31:0]         issue_pc,
    input  logic                issue_pred_taken,
    input  logic                issue_ready,
    input  logic [31:0]         issue_value,
    output logic                rob_full,
    output logic [ROB_ID_W-1:0] alloc_rob_id,
    input  logic                alu_valid,
    input  logic [ROB_ID_W-1:0] alu_rob_id,
    input  logic [31:0]         alu_value,
    input  logic                alu_jump,
    input  logic [31:0]         alu_jump_pc,
    input  logic                lsb_valid,
    input  logic [ROB_ID_W-1:0] lsb_rob_id,
    input  logic [31:0]         lsb_value,
    input  logic [ROB_ID_W-1:0] q1_rob_id,
    output logic                q1_ready,
    output logic [31:0]         q1_value,
    input  logic [ROB_ID_W-1:0] q2_rob_id,
    output logic                q2_ready,
    output logic [31:0]         q2_value,
    output logic                is_commit,
    output logic [4:0]          commit_rd,
    output logic [31:0]         commit_data,
    output logic [ROB_ID_W-1:0] commit_rob_id,
    output logic [31:0]         commit_pc,
    output logic                commit_store,
    output logic                rollback,
    output logic [31:0]         redirect_pc
);

    import reorder_buffer_pkg::*;

    localparam int CNT_W = ROB_ID_W + 1;

    logic [ROB_ID_W-1:0] head_q, head_d;
    logic [ROB_ID_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0]    count_q, count_d;

    logic                is_commit_q, commit_store_q, rollback_q;
    logic [4:0]          commit_rd_q;
    logic [31:0]         commit_data_q, commit_pc_q, redirect_pc_q;
    logic [ROB_ID_W-1:0] commit_rob_id_q;

    // Flattened per-entry views used by the head mux and the query ports.
    logic [ROB_SZ-1:0]   ent_done;
    logic [31:0]         ent_value  [ROB_SZ];
    rob_type_e           ent_type   [ROB_SZ];
    logic [4:0]          ent_rd     [ROB_SZ];
    logic [31:0]         ent_pc     [ROB_SZ];
    logic [31:0]         ent_jpc    [ROB_SZ];
    logic [ROB_SZ-1:0]   ent_pred;
    logic [ROB_SZ-1:0]   ent_jump;

    logic issue_fire;
    logic commit_fire;
    logic flush;

    assign rob_full     = (count_q == CNT_W'(ROB_SZ));
    assign alloc_rob_id = tail_q;
    assign issue_fire   = issue_valid && !rob_full;

    // ent_done is cleared whenever an entry is freed, so a set bit at the head
    // implies the head is live; the count check keeps this explicit.
    assign commit_fire  = (count_q != '0) && ent_done[head_q];
    assign flush        = commit_fire &&
                          rob_needs_redirect(ent_type[head_q], ent_jump[head_q], ent_pred[head_q]);

    for (genvar gi = 0; gi < ROB_SZ; gi++) begin : g_entry
        logic      busy_q, ready_q, pred_q, jump_q;
        rob_type_e type_q;
        logic [4:0]  rd_q;
        logic [31:0] pc_q, value_q, jpc_q;
        logic sel_issue, sel_commit, hit_alu, hit_lsb;

        assign sel_issue  = issue_fire  && (tail_q == ROB_ID_W'(gi));
        assign sel_commit = commit_fire && (head_q == ROB_ID_W'(gi));
        assign hit_alu    = alu_valid && (alu_rob_id == ROB_ID_W'(gi));
        assign hit_lsb    = lsb_valid && (lsb_rob_id == ROB_ID_W'(gi));

        // Priority: flush > issue > free-on-commit > writeback. Issue and
        // commit can only select the same slot when the buffer is empty (no
        // commit) or full (no issue), so they never really collide.
        always_ff @(posedge clk) begin
            if (rst) begin
                busy_q  <= 1'b0;
                ready_q <= 1'b0;
            end else if (rdy) begin
                if (flush) begin
                    busy_q  <= 1'b0;
                    ready_q <= 1'b0;
                end else if (sel_issue) begin
                    busy_q  <= 1'b1;
                    ready_q <= issue_ready;
                    type_q  <= rob_type_e'(issue_type);
                    rd_q    <= issue_rd;
                    pc_q    <= issue_pc;
                    value_q <= issue_value;
                    pred_q  <= issue_pred_taken;
                    jump_q  <= 1'b0;
                    jpc_q   <= 32'd0;
                end else if (sel_commit) begin
                    busy_q  <= 1'b0;
                    ready_q <= 1'b0;
                end else if (busy_q) begin
                    if (hit_alu) begin
                        ready_q <= 1'b1;
                        value_q <= alu_value;
                        jump_q  <= alu_jump;
                        jpc_q   <= alu_jump_pc;
                    end else if (hit_lsb) begin
                        ready_q <= 1'b1;
                        value_q <= lsb_value;
                    end
                end
            end
        end

        assign ent_done[gi]  = busy_q && ready_q;
        assign ent_value[gi] = value_q;
        assign ent_type[gi]  = type_q;
        assign ent_rd[gi]    = rd_q;
        assign ent_pc[gi]    = pc_q;
        assign ent_jpc[gi]   = jpc_q;
        assign ent_pred[gi]  = pred_q;
        assign ent_jump[gi]  = jump_q;
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (commit_fire) head_d = head_q + 1'b1;
            if (issue_fire)  tail_d = tail_q + 1'b1;
            count_d = count_q + CNT_W'(issue_fire) - CNT_W'(commit_fire);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            is_commit_q     <= 1'b0;
            commit_store_q  <= 1'b0;
            rollback_q      <= 1'b0;
            commit_rd_q     <= 5'd0;
            commit_data_q   <= 32'd0;
            commit_rob_id_q <= '0;
            commit_pc_q     <= 32'd0;
            redirect_pc_q   <= 32'd0;
        end else if (rdy) begin
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            is_commit_q    <= 1'b0;
            commit_store_q <= 1'b0;
            rollback_q     <= 1'b0;
            if (commit_fire) begin
                commit_rob_id_q <= head_q;
                commit_pc_q     <= ent_pc[head_q];
                commit_data_q   <= ent_value[head_q];
                // Branches and stores never write the register file.
                commit_rd_q     <= ((ent_type[head_q] == ENT_BR) || (ent_type[head_q] == ENT_STORE))
                                   ? 5'd0 : ent_rd[head_q];
                is_commit_q     <= (ent_type[head_q] != ENT_STORE);
                commit_store_q  <= (ent_type[head_q] == ENT_STORE);
                if (flush) begin
                    rollback_q    <= 1'b1;
                    redirect_pc_q <= ent_jpc[head_q];
                end
            end
        end
    end

    assign is_commit     = is_commit_q;
    assign commit_store  = commit_store_q;
    assign rollback      = rollback_q;
    assign commit_rd     = commit_rd_q;
    assign commit_data   = commit_data_q;
    assign commit_rob_id = commit_rob_id_q;
    assign commit_pc     = commit_pc_q;
    assign redirect_pc   = redirect_pc_q;

    rob_query_port #(.ROB_SZ(ROB_SZ), .ROB_ID_W(ROB_ID_W)) u_q1 (
        .q_rob_id_i   (q1_rob_id),
        .ent_ready_i  (ent_done),
        .ent_value_i  (ent_value),
        .alu_valid_i  (alu_valid),
        .alu_rob_id_i (alu_rob_id),
        .alu_value_i  (alu_value),
        .lsb_valid_i  (lsb_valid),
        .lsb_rob_id_i (lsb_rob_id),
        .lsb_value_i  (lsb_value),
        .q_ready_o    (q1_ready),
        .q_value_o    (q1_value)
    );

    rob_query_port #(.ROB_SZ(ROB_SZ), .ROB_ID_W(ROB_ID_W)) u_q2 (
        .q_rob_id_i   (q2_rob_id),
        .ent_ready_i  (ent_done),
        .ent_value_i  (ent_value),
        .alu_valid_i  (alu_valid),
        .alu_rob_id_i (alu_rob_id),
        .alu_value_i  (alu_value),
        .lsb_valid_i  (lsb_valid),
        .lsb_rob_id_i (lsb_rob_id),
        .lsb_value_i  (lsb_value),
        .q_ready_o    (q2_ready),
        .q_value_o    (q2_value)
    );

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a queue model.
module tb_reorder_buffer;

    localparam int SZ = 16;
    localparam logic [1:0] T_NORM = 2'd0, T_BR = 2'd1, T_STORE = 2'd2, T_JALR = 2'd3;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        issue_valid, issue_pred_taken, issue_ready;
    logic [1:0]  issue_type;
    logic [4:0]  issue_rd;
    logic [31:0] issue_pc, issue_value;
    logic        rob_full;
    logic [3:0]  alloc_rob_id;
    logic        alu_valid, alu_jump;
    logic [3:0]  alu_rob_id;
    logic [31:0] alu_value, alu_jump_pc;
    logic        lsb_valid;
    logic [3:0]  lsb_rob_id;
    logic [31:0] lsb_value;
    logic [3:0]  q1_rob_id, q2_rob_id;
    logic        q1_ready, q2_ready;
    logic [31:0] q1_value, q2_value;
    logic        is_commit, commit_store, rollback;
    logic [4:0]  commit_rd;
    logic [31:0] commit_data, commit_pc, redirect_pc;
    logic [3:0]  commit_rob_id;

    reorder_buffer dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .issue_valid(issue_valid), .issue_type(issue_type), .issue_rd(issue_rd),
        .issue_pc(issue_pc), .issue_pred_taken(issue_pred_taken),
        .issue_ready(issue_ready), .issue_value(issue_value),
        .rob_full(rob_full), .alloc_rob_id(alloc_rob_id),
        .alu_valid(alu_valid), .alu_rob_id(alu_rob_id), .alu_value(alu_value),
        .alu_jump(alu_jump), .alu_jump_pc(alu_jump_pc),
        .lsb_valid(lsb_valid), .lsb_rob_id(lsb_rob_id), .lsb_value(lsb_value),
        .q1_rob_id(q1_rob_id), .q1_ready(q1_ready), .q1_value(q1_value),
        .q2_rob_id(q2_rob_id), .q2_ready(q2_ready), .q2_value(q2_value),
        .is_commit(is_commit), .commit_rd(commit_rd), .commit_data(commit_data),
        .commit_rob_id(commit_rob_id), .commit_pc(commit_pc),
        .commit_store(commit_store), .rollback(rollback), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model: oldest entry at index 0 -------------
    typedef struct {
        logic [1:0]  typ;
        logic [4:0]  rd;
        logic [31:0] pc, value, jpc;
        logic        pred, ready, jump;
    } ent_t;

    ent_t rob[$];
    int   head = 0;
    logic        e_is_commit = 0, e_store = 0, e_rollback = 0;
    logic [4:0]  e_rd = 0;
    logic [31:0] e_data = 0, e_pc = 0, e_redirect = 0;
    logic [3:0]  e_id = 0;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Position of a tag inside the model queue, or -1 when not allocated.
    function automatic int pos_of(input logic [3:0] id);
        int k;
        k = (int'(id) - head + SZ) % SZ;
        return (k < rob.size()) ? k : -1;
    endfunction

    task automatic exp_query(input logic [3:0] id, output logic r, output logic [31:0] v);
        int k;
        k = pos_of(id);
        r = 1'b0; v = 32'd0;
        if (k >= 0 && rob[k].ready) begin r = 1'b1; v = rob[k].value; end
        else if (alu_valid && alu_rob_id == id) begin r = 1'b1; v = alu_value; end
        else if (lsb_valid && lsb_rob_id == id) begin r = 1'b1; v = lsb_value; end
    endtask

    task automatic compare_all();
        logic r; logic [31:0] v;
        chk("rob_full", rob_full, rob.size() == SZ);
        chk("alloc_rob_id", alloc_rob_id, (head + rob.size()) % SZ);
        exp_query(q1_rob_id, r, v);
        chk("q1_ready", q1_ready, r);
        chk("q1_value", q1_value, v);
        exp_query(q2_rob_id, r, v);
        chk("q2_ready", q2_ready, r);
        chk("q2_value", q2_value, v);
        chk("is_commit", is_commit, e_is_commit);
        chk("commit_store", commit_store, e_store);
        chk("rollback", rollback, e_rollback);
        if (e_is_commit || e_store) begin
            chk("commit_rob_id", commit_rob_id, e_id);
            chk("commit_pc", commit_pc, e_pc);
        end
        if (e_is_commit) begin
            chk("commit_rd", commit_rd, e_rd);
            chk("commit_data", commit_data, e_data);
        end
        if (e_rollback) chk("redirect_pc", redirect_pc, e_redirect);
    endtask

    // Applies one clock edge of the specification rules to the model.
    task automatic model_update();
        bit do_commit, flush, was_full;
        ent_t c, n;
        int k;
        if (rst) begin
            rob.delete(); head = 0;
            e_is_commit = 0; e_store = 0; e_rollback = 0;
            e_rd = 0; e_data = 0; e_pc = 0; e_redirect = 0; e_id = 0;
            return;
        end
        if (!rdy) return;
        e_is_commit = 0; e_store = 0; e_rollback = 0;
        flush = 0;
        do_commit = rob.size() > 0 && rob[0].ready;
        was_full = rob.size() == SZ;
        if (do_commit) begin
            c = rob[0];
            e_id = 4'(head); e_pc = c.pc; e_data = c.value;
            case (c.typ)
                T_NORM:  begin e_is_commit = 1; e_rd = c.rd; end
                T_STORE: e_store = 1;
                T_BR:    begin e_is_commit = 1; e_rd = 0; flush = (c.jump != c.pred); end
                default: begin e_is_commit = 1; e_rd = c.rd; flush = 1; end
            endcase
            if (flush) begin e_rollback = 1; e_redirect = c.jpc; end
        end
        if (flush) begin rob.delete(); head = 0; return; end
        if (alu_valid) begin
            k = pos_of(alu_rob_id);
            if (k >= 0) begin
                rob[k].ready = 1; rob[k].value = alu_value;
                rob[k].jump = alu_jump; rob[k].jpc = alu_jump_pc;
            end
        end
        if (lsb_valid && !(alu_valid && alu_rob_id == lsb_rob_id)) begin
            k = pos_of(lsb_rob_id);
            if (k >= 0) begin rob[k].ready = 1; rob[k].value = lsb_value; end
        end
        if (do_commit) begin void'(rob.pop_front()); head = (head + 1) % SZ; end
        if (issue_valid && !was_full) begin
            n.typ = issue_type; n.rd = issue_rd; n.pc = issue_pc; n.value = issue_value;
            n.pred = issue_pred_taken; n.ready = issue_ready; n.jump = 0; n.jpc = 0;
            rob.push_back(n);
        end
    endtask

    // Called at a negedge with inputs set; returns at the next negedge.
    task automatic cycle();
        #1;
        compare_all();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 0; rdy = 1;
        issue_valid = 0; issue_type = 0; issue_rd = 0; issue_pc = 0;
        issue_pred_taken = 0; issue_ready = 0; issue_value = 0;
        alu_valid = 0; alu_rob_id = 0; alu_value = 0; alu_jump = 0; alu_jump_pc = 0;
        lsb_valid = 0; lsb_rob_id = 0; lsb_value = 0;
        q1_rob_id = 0; q2_rob_id = 0;
    endtask

    task automatic do_reset();
        idle(); rst = 1; cycle(); cycle(); rst = 0;
    endtask

    task automatic set_issue(input logic [1:0] t, input logic [4:0] rd, input logic [31:0] pc,
                             input logic pred, input logic rdyv, input logic [31:0] val);
        issue_valid = 1; issue_type = t; issue_rd = rd; issue_pc = pc;
        issue_pred_taken = pred; issue_ready = rdyv; issue_value = val;
    endtask

    task automatic alu_wb(input logic [3:0] id, input logic [31:0] val,
                          input logic j, input logic [31:0] jpc);
        alu_valid = 1; alu_rob_id = id; alu_value = val; alu_jump = j; alu_jump_pc = jpc;
    endtask

    initial begin
        int k;
        logic [3:0] id_a;
        idle();
        rst = 1;
        // First edges: outputs are undefined until reset is seen, so no compare.
        repeat (2) @(posedge clk);
        model_update();
        @(negedge clk);
        rst = 0;
        #1;
        chk("reset is_commit", is_commit, 0);
        chk("reset rollback", rollback, 0);
        chk("reset commit_store", commit_store, 0);
        chk("reset commit_data", commit_data, 0);
        chk("reset redirect_pc", redirect_pc, 0);
        chk("reset alloc_rob_id", alloc_rob_id, 0);

        // 1. NORM issue, writeback, commit two cycles after writeback.
        set_issue(T_NORM, 5'd5, 32'h100, 0, 0, 0); cycle(); idle();
        alu_wb(4'd0, 32'hAB, 0, 0); cycle(); idle();
        chk("t1 no commit yet", is_commit, 0);
        cycle();
        chk("t1 is_commit", is_commit, 1);
        chk("t1 commit_rd", commit_rd, 5);
        chk("t1 commit_data", commit_data, 32'hAB);
        chk("t1 commit_rob_id", commit_rob_id, 0);
        chk("t1 commit_pc", commit_pc, 32'h100);
        cycle();
        chk("t1 strobe drops", is_commit, 0);
        chk("t1 empty", rob_full, 0);

        // 2. Fill to 16, refuse the 17th, commit one, tail wraps.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            set_issue(T_NORM, 5'(i + 1), 32'h1000 + 32'(i * 4), 0, 0, 0); cycle();
        end
        idle();
        #1;
        chk("t2 rob_full", rob_full, 1);
        chk("t2 tail wrapped", alloc_rob_id, 0);
        set_issue(T_NORM, 5'd31, 32'hDEAD, 0, 1, 32'h55); cycle(); idle();
        chk("t2 17th ignored full", rob_full, 1);
        chk("t2 17th ignored tail", alloc_rob_id, 0);
        alu_wb(4'd0, 32'h11, 0, 0); cycle(); idle();
        cycle();
        chk("t2 commit id0", commit_rob_id, 0);
        chk("t2 rob_full dropped", rob_full, 0);
        set_issue(T_NORM, 5'd2, 32'h2000, 0, 0, 0); cycle(); idle();
        chk("t2 alloc after wrap", alloc_rob_id, 1);

        // 3. Out-of-order writeback, in-order retirement.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_issue(T_NORM, 5'(i + 7), 32'h300 + 32'(i * 4), 0, 0, 0); cycle();
        end
        idle();
        for (int i = 2; i >= 0; i--) begin
            alu_wb(4'(i), 32'(i + 100), 0, 0); cycle(); idle();
        end
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("t3 in-order is_commit", is_commit, 1);
            chk("t3 in-order id", commit_rob_id, i);
            chk("t3 in-order data", commit_data, i + 100);
        end
        cycle();
        chk("t3 done", is_commit, 0);

        // 4. Mispredicted branch flushes the younger NORM.
        do_reset();
        set_issue(T_BR, 5'd0, 32'h40, 0, 0, 0); cycle();
        set_issue(T_NORM, 5'd3, 32'h44, 0, 1, 32'h9); cycle(); idle();
        alu_wb(4'd0, 32'd0, 1, 32'h200); cycle(); idle();
        cycle();
        chk("t4 rollback", rollback, 1);
        chk("t4 redirect_pc", redirect_pc, 32'h200);
        chk("t4 br commit id", commit_rob_id, 0);
        cycle();
        chk("t4 rollback 1 cycle", rollback, 0);
        chk("t4 id1 not committed", is_commit, 0);
        chk("t4 alloc reset", alloc_rob_id, 0);
        cycle();
        chk("t4 id1 still not committed", is_commit, 0);

        // 5. Query forwarding from the ALU bus.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_issue(T_NORM, 5'd1, 32'h500, 0, 0, 0); cycle();
        end
        idle();
        q1_rob_id = 4'd3;
        #1;
        chk("t5 q1 not ready", q1_ready, 0);
        chk("t5 q1 value 0", q1_value, 0);
        cycle();
        q1_rob_id = 4'd3;
        alu_wb(4'd3, 32'd7, 0, 0);
        #1;
        chk("t5 q1 fwd ready", q1_ready, 1);
        chk("t5 q1 fwd value", q1_value, 7);
        cycle(); idle();

        // 6. Store commit, then reset mid-stream.
        do_reset();
        set_issue(T_STORE, 5'd0, 32'h600, 0, 0, 0); cycle(); idle();
        lsb_valid = 1; lsb_rob_id = 4'd0; lsb_value = 32'h1234; cycle(); idle();
        cycle();
        chk("t6 commit_store", commit_store, 1);
        chk("t6 store id", commit_rob_id, 0);
        chk("t6 store no is_commit", is_commit, 0);
        for (int i = 0; i < 4; i++) begin
            set_issue(T_NORM, 5'd9, 32'h700 + 32'(i), 0, 1, 32'hC0 + 32'(i)); cycle();
        end
        chk("t6 committing before rst", is_commit, 1);
        idle(); rst = 1; cycle(); rst = 0;
        chk("t6 rst is_commit", is_commit, 0);
        chk("t6 rst commit_data", commit_data, 0);
        chk("t6 rst commit_pc", commit_pc, 0);
        chk("t6 rst commit_rd", commit_rd, 0);
        chk("t6 rst alloc", alloc_rob_id, 0);
        chk("t6 rst full", rob_full, 0);

        // Randomized traffic.
        for (int n = 0; n < 4000; n++) begin
            idle();
            rst = ($urandom_range(0, 999) < 3);
            rdy = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 1) == 1) begin
                k = $urandom_range(0, 19);
                set_issue(k < 12 ? T_NORM : k < 15 ? T_STORE : k < 18 ? T_BR : T_JALR,
                          5'($urandom), $urandom, 1'($urandom),
                          ($urandom_range(0, 3) == 0), $urandom);
            end
            if (rob.size() > 0 && $urandom_range(0, 2) != 0) begin
                k = $urandom_range(0, rob.size() - 1);
                alu_wb(4'((head + k) % SZ), $urandom, 1'($urandom), $urandom);
            end else if ($urandom_range(0, 7) == 0) begin
                alu_wb(4'($urandom), $urandom, 1'($urandom), $urandom);
            end
            if ($urandom_range(0, 2) == 0) begin
                id_a = (rob.size() > 0) ? 4'((head + $urandom_range(0, rob.size() - 1)) % SZ)
                                        : 4'($urandom);
                if (!(alu_valid && alu_rob_id == id_a)) begin
                    lsb_valid = 1; lsb_rob_id = id_a; lsb_value = $urandom;
                end
            end
            q1_rob_id = ($urandom_range(0, 3) == 0 && alu_valid) ? alu_rob_id : 4'($urandom);
            q2_rob_id = ($urandom_range(0, 3) == 0 && lsb_valid) ? lsb_rob_id : 4'($urandom);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
